// File: rtl/fanout_buf_pkg.sv
// Shared helpers for the fanout skid buffer: counter-width sizing and
// parameter legality checks.
package fanout_buf_pkg;

    localparam int unsigned MIN_LOADS = 1;
    localparam int unsigned MIN_DEPTH = 1;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic bit params_ok(input int unsigned num_loads, input int unsigned depth);
        return (num_loads >= MIN_LOADS) && (depth >= MIN_DEPTH);
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// Per-branch DEPTH-entry FIFO with registered count/full/empty flags.
module branch_fifo
    import fanout_buf_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = clog2_min1(DEPTH + 1),
    localparam int unsigned PW    = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Wrap explicitly so non-power-of-two depths index only valid slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Push and pop together leave count and flags unchanged.
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + CW'(1);
                    full  <= (count == CW'(DEPTH - 1));
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - CW'(1);
                    full  <= 1'b0;
                    empty <= (count == CW'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fanout_skid_buffer.sv
// Broadcasts one valid/ready stream to NUM_LOADS buffered branches; a branch
// only back-pressures the driver when it is enabled and its buffer is full.
module fanout_skid_buffer
    import fanout_buf_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned NUM_LOADS = 4,
    parameter  int unsigned DEPTH     = 2,
    localparam int unsigned CW        = clog2_min1(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [NUM_LOADS-1:0]       load_en,
    output logic [NUM_LOADS-1:0]       out_valid,
    input  logic [NUM_LOADS-1:0]       out_ready,
    output logic [NUM_LOADS*WIDTH-1:0] out_data,
    output logic [NUM_LOADS*CW-1:0]    occupancy
);

    if (!params_ok(NUM_LOADS, DEPTH)) begin : g_param_err
        $error("fanout_skid_buffer: NUM_LOADS and DEPTH must both be at least 1");
    end

    logic [NUM_LOADS-1:0] full;
    logic [NUM_LOADS-1:0] empty;
    logic [NUM_LOADS-1:0] push;
    logic                 all_ready;
    logic                 accept;

    // Readiness depends only on registered full flags, never on out_ready.
    always_comb begin
        all_ready = 1'b1;
        for (int i = 0; i < int'(NUM_LOADS); i++) begin
            if (load_en[i] && full[i]) begin
                all_ready = 1'b0;
            end
        end
    end

    assign in_ready  = !rst && all_ready;
    assign accept    = in_valid && in_ready;
    assign push      = {NUM_LOADS{accept}} & load_en;
    assign out_valid = ~empty;

    for (genvar g = 0; g < int'(NUM_LOADS); g++) begin : g_branch
        branch_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (out_ready[g]),
            .wdata (in_data),
            .rdata (out_data[g*WIDTH +: WIDTH]),
            .count (occupancy[g*CW +: CW]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

endmodule

// File: tb/tb_fanout_skid_buffer.sv
// Directed-vector bench for fanout_skid_buffer (WIDTH=8, NUM_LOADS=4, DEPTH=2).
module tb_fanout_skid_buffer;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_LOADS = 4;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned CW        = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_data;
    logic [NUM_LOADS-1:0]       load_en;
    logic [NUM_LOADS-1:0]       out_valid;
    logic [NUM_LOADS-1:0]       out_ready;
    logic [NUM_LOADS*WIDTH-1:0] out_data;
    logic [NUM_LOADS*CW-1:0]    occupancy;

    int n_vec = 0;
    int n_miss = 0;

    fanout_skid_buffer #(
        .WIDTH     (WIDTH),
        .NUM_LOADS (NUM_LOADS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .load_en   (load_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] head(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [1:0] occ(input int i);
        return occupancy[i*CW +: CW];
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bcast [3];
        bcast[0] = 8'h11;
        bcast[1] = 8'h22;
        bcast[2] = 8'h33;

        // Reset held with a word on the input
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; load_en = 4'hF; out_ready = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_occupancy", 32'(occupancy), 32'h0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("release_out_valid", 32'(out_valid), 32'h0);

        // Broadcast, all loads draining every cycle
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = bcast[k];
            tick();
            chk("bc_valid", 32'(out_valid), 32'hF);
            chk("bc_occ", 32'(occupancy), 32'h55);
            for (int i = 0; i < 4; i++) chk("bc_data", 32'(head(i)), 32'(bcast[k]));
        end
        in_valid = 1'b0;
        tick();
        chk("bc_drained", 32'(out_valid), 32'h0);

        // Slow branch 0 fills and back-pressures
        out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'h01;
        #1;
        chk("slow_ready0", 32'(in_ready), 32'h1);
        tick();
        in_data = 8'h02;
        #1;
        chk("slow_ready1", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("slow_occ0_full", 32'(occ(0)), 32'h2);
        chk("slow_head0", 32'(head(0)), 32'h01);
        chk("slow_head1", 32'(head(1)), 32'h02);
        chk("slow_ready_low", 32'(in_ready), 32'h0);
        out_ready = 4'hF;
        tick();
        out_ready = 4'b1110;
        #1;
        chk("slow_ready_back", 32'(in_ready), 32'h1);
        chk("slow_head0_after", 32'(head(0)), 32'h02);
        chk("slow_occ0_after", 32'(occ(0)), 32'h1);
        chk("slow_valid_after", 32'(out_valid), 32'h1);

        // Fill branch 1 only, then mask it out
        out_ready = 4'h0; load_en = 4'b0010; in_valid = 1'b1; in_data = 8'hAB;
        tick();
        in_data = 8'hCD;
        tick();
        load_en = 4'b0101; in_data = 8'h5A;
        #1;
        chk("mask_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("mask_occ", 32'(occupancy), 32'h1A);
        chk("mask_valid", 32'(out_valid), 32'h7);
        chk("mask_head1", 32'(head(1)), 32'hAB);
        chk("mask_head2", 32'(head(2)), 32'h5A);
        chk("mask_ready_b0full", 32'(in_ready), 32'h0);
        load_en = 4'hF; out_ready = 4'hF;
        tick();
        chk("mask_b0_second", 32'(head(0)), 32'h5A);
        chk("mask_b1_second", 32'(head(1)), 32'hCD);
        chk("mask_occ_drain", 32'(occupancy), 32'h05);
        tick();
        chk("mask_all_empty", 32'(out_valid), 32'h0);

        // Simultaneous push and pop on branch 2
        load_en = 4'b0100; out_ready = 4'b0100; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'(8'h80 + k);
            tick();
            chk("pp_occ2", 32'(occ(2)), 32'h1);
            chk("pp_head2", 32'(head(2)), 32'(8'h80 + k));
            chk("pp_valid", 32'(out_valid), 32'h4);
        end
        in_valid = 1'b0;
        tick();
        chk("pp_drained", 32'(out_valid), 32'h0);

        // Fill everything, then reset mid-operation
        load_en = 4'hF; out_ready = 4'h0; in_valid = 1'b1; in_data = 8'hE1;
        tick();
        in_data = 8'hE2;
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_occ", 32'(occupancy), 32'hAA);
        chk("full_ready", 32'(in_ready), 32'h0);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_occ", 32'(occupancy), 32'h0);
        rst = 1'b0; out_ready = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_valid", 32'(out_valid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
